// File: rtl/column_window_reader_pkg.sv
// Shared defaults and state encoding for the column window reader.
// Edge handling is selected by COLREAD_ZERO_PAD_EN in window_shift3.
package column_window_reader_pkg;

    localparam int unsigned hwidth       = 640;
    localparam int unsigned awidth_pbuff = 10;
    localparam int unsigned dwidth_dat   = 12;
    localparam int unsigned dwidth_slice = 3;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FILL   = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;

    typedef enum logic [1:0] {
        StIdle   = IDLE,
        StFill   = FILL,
        StStream = STREAM
    } state_e;

    // Increment that clamps at lim, so the right edge column is re-read.
    function automatic int unsigned sat_inc(input int unsigned a, input int unsigned lim);
        return (a >= lim) ? lim : a + 1;
    endfunction

endpackage

// File: rtl/column_window_reader_window_shift3.sv
// Three-column shift register (left, center, right) feeding the window output.
// COLREAD_ZERO_PAD_EN: edge neighbours are zero instead of replicated.
module window_shift3
    import column_window_reader_pkg::*;
#(
    parameter int unsigned CWIDTH = dwidth_dat * dwidth_slice
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  fill_i,
    input  logic                  shift_i,
    input  logic                  last_i,
    input  logic [CWIDTH-1:0]     col_i,
    output logic [3*CWIDTH-1:0]   win_o
);

`ifdef COLREAD_ZERO_PAD_EN
    localparam bit ZeroPad = 1'b1;
`else
    localparam bit ZeroPad = 1'b0;
`endif

    logic [CWIDTH-1:0] c0_q, c0_d;
    logic [CWIDTH-1:0] c1_q, c1_d;
    logic [CWIDTH-1:0] c2_q, c2_d;

    always_comb begin
        c0_d = c0_q;
        c1_d = c1_q;
        c2_d = c2_q;
        if (load_i) begin
            // Column 0 is its own left neighbour unless padding with zero.
            c0_d = ZeroPad ? '0 : col_i;
            c1_d = col_i;
        end else if (fill_i) begin
            c2_d = col_i;
        end else if (shift_i) begin
            c0_d = c1_q;
            c1_d = c2_q;
            c2_d = (ZeroPad && last_i) ? '0 : col_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            c0_q <= '0;
            c1_q <= '0;
            c2_q <= '0;
        end else begin
            c0_q <= c0_d;
            c1_q <= c1_d;
            c2_q <= c2_d;
        end
    end

    assign win_o = {c2_q, c1_q, c0_q};

endmodule

// File: rtl/column_window_reader.sv
// Scans columns 0..HWIDTH-1 after each line commit and streams 3-column windows.
// COLREAD_ZERO_PAD_EN (in window_shift3) selects zero edge padding.
module column_window_reader
    import column_window_reader_pkg::*;
#(
    parameter int unsigned HWIDTH = hwidth,
    parameter int unsigned AWIDTH = awidth_pbuff,
    parameter int unsigned DWIDTH = dwidth_dat,
    parameter int unsigned SLICE  = dwidth_slice
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        line_ready,
    output logic [AWIDTH-1:0]           raddr,
    input  logic [DWIDTH*SLICE-1:0]     col_in,
    output logic                        win_valid,
    input  logic                        win_ready,
    output logic [3*DWIDTH*SLICE-1:0]   win_data,
    output logic [AWIDTH-1:0]           win_col,
    output logic                        busy,
    output logic                        overrun
);

    localparam int unsigned CWIDTH = DWIDTH * SLICE;
    localparam logic [AWIDTH-1:0] LastCol = AWIDTH'(HWIDTH - 1);

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] raddr_q, raddr_d;
    logic [AWIDTH-1:0] win_col_q, win_col_d;
    logic              win_valid_q, win_valid_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;

    logic load, fill, shift, last;
    logic accept;

    assign accept = win_valid_q && win_ready;

    always_comb begin
        state_d     = state_q;
        raddr_d     = raddr_q;
        win_col_d   = win_col_q;
        win_valid_d = win_valid_q;
        overrun_d   = overrun_q;
        load        = 1'b0;
        fill        = 1'b0;
        shift       = 1'b0;
        last        = 1'b0;

        unique case (state_q)
            StIdle: begin
                raddr_d = '0;
                if (line_ready) begin
                    load    = 1'b1;
                    raddr_d = AWIDTH'(sat_inc(32'(raddr_q), HWIDTH - 1));
                    state_d = StFill;
                end
            end
            StFill: begin
                fill        = 1'b1;
                raddr_d     = AWIDTH'(sat_inc(32'(raddr_q), HWIDTH - 1));
                win_col_d   = '0;
                win_valid_d = 1'b1;
                state_d     = StStream;
            end
            StStream: begin
                if (accept) begin
                    if (win_col_q == LastCol) begin
                        win_valid_d = 1'b0;
                        raddr_d     = '0;
                        state_d     = StIdle;
                    end else begin
                        shift     = 1'b1;
                        last      = (win_col_q == LastCol - AWIDTH'(1));
                        win_col_d = win_col_q + AWIDTH'(1);
                        raddr_d   = AWIDTH'(sat_inc(32'(raddr_q), HWIDTH - 1));
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A commit during a scan is dropped; only the sticky flag records it.
        if (state_q != StIdle && line_ready) begin
            overrun_d = 1'b1;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            raddr_q     <= '0;
            win_col_q   <= '0;
            win_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            raddr_q     <= raddr_d;
            win_col_q   <= win_col_d;
            win_valid_q <= win_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    window_shift3 #(
        .CWIDTH (CWIDTH)
    ) u_window_shift3 (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .fill_i  (fill),
        .shift_i (shift),
        .last_i  (last),
        .col_i   (col_in),
        .win_o   (win_data)
    );

    assign raddr     = raddr_q;
    assign win_col   = win_col_q;
    assign win_valid = win_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_column_window_reader.sv
// Bench for column_window_reader: column k holds three pixels of value k; windows
// are checked against a model of the expected neighbourhood of each column index.
module tb_column_window_reader;

    localparam int HW = 640;
    localparam int AW = 10;
    localparam int DW = 12;
    localparam int SL = 3;
    localparam int CW = DW * SL;

`ifdef COLREAD_ZERO_PAD_EN
    localparam bit Pad = 1'b1;
`else
    localparam bit Pad = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 line_ready;
    logic [AW-1:0]        raddr;
    logic [CW-1:0]        col_in;
    logic                 win_valid;
    logic                 win_ready;
    logic [3*CW-1:0]      win_data;
    logic [AW-1:0]        win_col;
    logic                 busy;
    logic                 overrun;

    int checks   = 0;
    int failures = 0;
    bit exp_ovr  = 1'b0;

    always #5 clk = ~clk;

    // Column buffer stand-in: combinational read, column k = {k, k, k}.
    assign col_in = {SL{DW'(raddr)}};

    column_window_reader dut (
        .clk        (clk),
        .rst        (rst),
        .line_ready (line_ready),
        .raddr      (raddr),
        .col_in     (col_in),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_data   (win_data),
        .win_col    (win_col),
        .busy       (busy),
        .overrun    (overrun)
    );

    function automatic logic [CW-1:0] pix(input int c);
        return {SL{DW'(c)}};
    endfunction

    function automatic logic [3*CW-1:0] exp_win(input int k);
        logic [CW-1:0] l, c, r;
        l = (k == 0) ? (Pad ? '0 : pix(0)) : pix(k - 1);
        c = pix(k);
        r = (k == HW - 1) ? (Pad ? '0 : pix(HW - 1)) : pix(k + 1);
        return {r, c, l};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_raddr"},   128'(raddr),     128'(0));
        chk({tag, "_valid"},   128'(win_valid), 128'(0));
        chk({tag, "_data"},    128'(win_data),  128'(0));
        chk({tag, "_col"},     128'(win_col),   128'(0));
        chk({tag, "_busy"},    128'(busy),      128'(0));
        chk({tag, "_overrun"}, 128'(overrun),   128'(0));
    endtask

    // One line scan. stall_at: hold ready low 5 cycles there; lr_at: inject a commit
    // while busy; rst_at: reset mid-scan. Negative values disable each feature.
    task automatic do_scan(input bit rnd, input int stall_at, input int lr_at, input int rst_at);
        int  k;
        int  cyc;
        int  stalls;
        bit  acc;
        bit  did_lr;
        int  ra;
        k      = 0;
        cyc    = 0;
        stalls = 0;
        did_lr = 1'b0;
        line_ready = 1'b1;
        step();
        line_ready = 1'b0;
        chk("lat_busy",   128'(busy),      128'(1));
        chk("lat_valid0", 128'(win_valid), 128'(0));
        step();
        chk("fill_valid", 128'(win_valid), 128'(1));
        while (k < HW && cyc < 20000) begin
            ra = (k + 2 > HW - 1) ? HW - 1 : k + 2;
            chk("valid",    128'(win_valid), 128'(1));
            chk("busy",     128'(busy),      128'(1));
            chk("win_col",  128'(win_col),   128'(k));
            chk("win_data", 128'(win_data),  128'(exp_win(k)));
            chk("raddr",    128'(raddr),     128'(ra));
            if (k == rst_at) begin
                rst = 1'b0;
                step();
                chk_reset("midrst");
                rst     = 1'b1;
                exp_ovr = 1'b0;
                win_ready = 1'b1;
                return;
            end
            acc = 1'b1;
            if (k == stall_at && stalls < 5) begin
                acc = 1'b0;
                stalls++;
            end else if (rnd) begin
                acc = ($urandom_range(0, 3) != 0);
            end
            if (k == lr_at && !did_lr) begin
                line_ready = 1'b1;
                did_lr     = 1'b1;
                exp_ovr    = 1'b1;
            end
            win_ready = acc;
            step();
            line_ready = 1'b0;
            cyc++;
            if (acc) k++;
        end
        win_ready = 1'b1;
        chk("scan_done", 128'(k),         128'(HW));
        chk("end_valid", 128'(win_valid), 128'(0));
        chk("end_busy",  128'(busy),      128'(0));
        chk("end_raddr", 128'(raddr),     128'(0));
        chk("overrun",   128'(overrun),   128'(exp_ovr));
    endtask

    initial begin
        rst        = 1'b0;
        line_ready = 1'b0;
        win_ready  = 1'b1;
        step();
        step();
        chk_reset("reset");
        rst = 1'b1;
        step();

        // Free run, then a second line straight after busy falls.
        do_scan(1'b0, -1, -1, -1);
        do_scan(1'b0, -1, -1, -1);

        // Backpressure at column 100.
        step();
        do_scan(1'b0, 100, -1, -1);

        // Random backpressure.
        step();
        do_scan(1'b1, -1, -1, -1);

        // Commit while busy: scan unaffected, overrun sticky until reset.
        step();
        do_scan(1'b0, -1, 300, -1);
        step();
        step();
        step();
        chk("ovr_sticky", 128'(overrun), 128'(1));
        chk("ovr_idle",   128'(busy),    128'(0));

        // Reset mid-scan, then a clean restart with random backpressure.
        do_scan(1'b0, -1, -1, 300);
        step();
        chk_reset("post_rst");
        do_scan(1'b1, -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
